// File: rtl/bmc_pkg.sv
// Shared definitions for the Viterbi branch-metric, ACS and path-metric blocks.
// Metric widths are derived from code rate and soft-value width.
package bmc_pkg;

    localparam int CODE_N_MAX = 4;
    localparam int SOFT_W_MAX = 8;

    function automatic int smax_of(input int soft_w);
        return (1 << soft_w) - 1;
    endfunction

    function automatic int met_w_of(input int code_n, input int soft_w);
        return $clog2(code_n * smax_of(soft_w) + 1);
    endfunction

    localparam int MET_W_MAX = met_w_of(CODE_N_MAX, SOFT_W_MAX);

    // Wide enough for any supported rate and soft width.
    typedef logic [MET_W_MAX-1:0] metric_t;

endpackage

// File: rtl/bmc_sym_dist.sv
// Per-symbol distances to an expected '0' and '1', with hard slicing
// and erasure masking.
module bmc_sym_dist
    import bmc_pkg::*;
#(
    parameter int SOFT_W = 3
) (
    input  logic [SOFT_W-1:0] r,
    input  logic              erase,
    input  logic              hard,
    output logic [SOFT_W-1:0] d0,
    output logic [SOFT_W-1:0] d1
);

    localparam logic [SOFT_W-1:0] SMAX = SOFT_W'(smax_of(SOFT_W));

    logic [SOFT_W-1:0] e;

    // SMAX is all ones, so hard slicing is the MSB replicated.
    always_comb begin
        e  = hard ? {SOFT_W{r[SOFT_W-1]}} : r;
        d0 = erase ? '0 : e;
        d1 = erase ? '0 : SMAX - e;
    end

endmodule

// File: rtl/bmc_soft_pipe.sv
// Two-stage soft/hard branch-metric unit: distances in S1,
// metrics and minimum index in S2, valid/ready on both sides.
module bmc_soft_pipe
    import bmc_pkg::*;
#(
    parameter  int CODE_N = 2,
    parameter  int SOFT_W = 3,
    localparam int MET_W  = met_w_of(CODE_N, SOFT_W),
    localparam int NH     = 1 << CODE_N
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CODE_N*SOFT_W-1:0] in_soft,
    input  logic [CODE_N-1:0]        in_erase,
    input  logic                     in_hard,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NH*MET_W-1:0]      out_metric,
    output logic [CODE_N-1:0]        out_min_idx,
    output logic                     out_all_erased
);

    typedef logic [CODE_N-1:0][SOFT_W-1:0] dvec_t;

    typedef struct packed {
        dvec_t d0;
        dvec_t d1;
        logic  all_er;
    } s1_t;

    typedef struct packed {
        logic [NH-1:0][MET_W-1:0] metric;
        logic [CODE_N-1:0]        min_idx;
        logic                     all_er;
    } s2_t;

    dvec_t d0_c;
    dvec_t d1_c;
    s1_t   s1_c;
    s1_t   s1;
    s2_t   s2_c;
    s2_t   s2;
    logic  s1_valid;
    logic  s2_valid;
    logic  s1_adv;
    logic  s2_adv;

    for (genvar i = 0; i < CODE_N; i++) begin : g_sym
        bmc_sym_dist #(
            .SOFT_W (SOFT_W)
        ) u_dist (
            .r     (in_soft[i*SOFT_W +: SOFT_W]),
            .erase (in_erase[i]),
            .hard  (in_hard),
            .d0    (d0_c[i]),
            .d1    (d1_c[i])
        );
    end

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s1_c.d0     = d0_c;
        s1_c.d1     = d1_c;
        s1_c.all_er = &in_erase;
    end

    // Adder trees, then a strict-less-than scan so ties keep the lowest h.
    always_comb begin
        metric_t          acc;
        logic [MET_W-1:0] best;
        s2_c = '0;
        for (int h = 0; h < NH; h++) begin
            acc = '0;
            for (int i = 0; i < CODE_N; i++) begin
                acc = acc + metric_t'(h[i] ? s1.d1[i] : s1.d0[i]);
            end
            s2_c.metric[h] = MET_W'(acc);
        end
        best = s2_c.metric[0];
        for (int h = 1; h < NH; h++) begin
            if (s2_c.metric[h] < best) begin
                best         = s2_c.metric[h];
                s2_c.min_idx = CODE_N'(h);
            end
        end
        s2_c.all_er = s1.all_er;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1 <= s1_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2       <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2 <= s2_c;
            end
        end
    end

    assign out_valid      = s2_valid;
    assign out_metric     = s2.metric;
    assign out_min_idx    = s2.min_idx;
    assign out_all_erased = s2.all_er;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Bench for bmc_soft_pipe: directed cases, backpressure, async reset,
// and random traffic against reference models (rate-1/2 soft and 1-bit legacy).
module tb_bmc_soft_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_soft;
    logic [1:0]  in_erase;
    logic        in_hard;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_metric;
    logic [1:0]  out_min_idx;
    logic        out_all_erased;

    logic        lrst_n;
    logic        lv;
    logic        lrdy;
    logic [1:0]  lsoft;
    logic [1:0]  lerase;
    logic        lhard;
    logic        lov;
    logic        lordy;
    logic [7:0]  lmetric;
    logic [1:0]  lmin;
    logic        lall;
    logic        ldone;

    int ntests;
    int nfail;

    logic [18:0] q[$];
    logic [10:0] lq[$];

    bmc_soft_pipe #(.CODE_N(2), .SOFT_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_soft        (in_soft),
        .in_erase       (in_erase),
        .in_hard        (in_hard),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_metric     (out_metric),
        .out_min_idx    (out_min_idx),
        .out_all_erased (out_all_erased)
    );

    bmc_soft_pipe #(.CODE_N(2), .SOFT_W(1)) u_leg (
        .clk            (clk),
        .rst_n          (lrst_n),
        .in_valid       (lv),
        .in_ready       (lrdy),
        .in_soft        (lsoft),
        .in_erase       (lerase),
        .in_hard        (lhard),
        .out_valid      (lov),
        .out_ready      (lordy),
        .out_metric     (lmetric),
        .out_min_idx    (lmin),
        .out_all_erased (lall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Rate-1/2, SMAX=7: metric = summed distance of effective values to
    // each hypothesis; hard mode snaps a value to 0 or 7 around mid-scale.
    function automatic logic [18:0] model_main(input logic [5:0] s,
                                               input logic [1:0] er,
                                               input logic hd);
        int m[4];
        int e[2];
        int bi;
        int r;
        logic [18:0] res;
        res = '0;
        for (int i = 0; i < 2; i++) begin
            r = int'(s[i*3 +: 3]);
            e[i] = hd ? ((r >= 4) ? 7 : 0) : r;
        end
        for (int h = 0; h < 4; h++) begin
            m[h] = 0;
            for (int i = 0; i < 2; i++) begin
                if (!er[i]) m[h] += ((h >> i) & 1) ? (7 - e[i]) : e[i];
            end
            res[h*4 +: 4] = 4'(m[h]);
        end
        bi = 0;
        for (int h = 1; h < 4; h++) if (m[h] < m[bi]) bi = h;
        res[17:16] = 2'(bi);
        res[18] = &er;
        return res;
    endfunction

    // Legacy 1-bit hard decision: metric is the Hamming distance.
    function automatic logic [10:0] model_leg(input logic [1:0] s);
        int m[4];
        int bi;
        logic [10:0] res;
        res = '0;
        for (int h = 0; h < 4; h++) begin
            m[h] = $countones(2'(h) ^ s);
            res[h*2 +: 2] = 2'(m[h]);
        end
        bi = 0;
        for (int h = 1; h < 4; h++) if (m[h] < m[bi]) bi = h;
        res[9:8] = 2'(bi);
        return res;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (in_valid && in_ready)
                q.push_back(model_main(in_soft, in_erase, in_hard));
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("sb_empty", 1, 0);
                else chk("sb", {out_all_erased, out_min_idx, out_metric},
                         q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (lrst_n) begin
            if (lv && lrdy) lq.push_back(model_leg(lsoft));
            if (lov && lordy) begin
                if (lq.size() == 0) chk("leg_empty", 1, 0);
                else chk("leg", {lall, lmin, lmetric}, lq.pop_front());
            end
        end
    end

    initial begin
        logic acc;
        lrst_n = 1'b0;
        lv = 1'b0;
        lsoft = '0;
        lerase = '0;
        lhard = 1'b0;
        lordy = 1'b0;
        ldone = 1'b0;
        acc = 1'b0;
        repeat (3) @(posedge clk);
        #1 lrst_n = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            if (!lv || acc) begin
                lv = $urandom_range(0, 3) != 0;
                lsoft = 2'($urandom);
                lhard = 1'($urandom_range(0, 1));
            end
            lordy = $urandom_range(0, 3) != 0;
            @(negedge clk);
            acc = lv && lrdy;
            @(posedge clk);
            #1;
        end
        lv = 1'b0;
        lordy = 1'b1;
        repeat (5) @(posedge clk);
        chk("leg_drain", lq.size(), 0);
        ldone = 1'b1;
    end

    task automatic run_one(input logic [2:0] r0, input logic [2:0] r1,
                           input logic [1:0] er, input logic hd,
                           input logic [15:0] em, input logic [1:0] emi,
                           input logic ea);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_soft = {r1, r0};
        in_erase = er;
        in_hard = hd;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("lat_early", out_valid, 0);
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("metric", out_metric, em);
        chk("min_idx", out_min_idx, emi);
        chk("all_er", out_all_erased, ea);
    endtask

    initial begin
        logic [5:0]  bp[4];
        logic [18:0] bexp[4];
        logic        acc;
        int          sent;
        int          nacc;
        int          got;
        ntests = 0;
        nfail = 0;
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_soft = '0;
        in_erase = '0;
        in_hard = 1'b0;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ov", out_valid, 0);
        chk("rst_metric", out_metric, 0);
        chk("rst_min", out_min_idx, 0);
        chk("rst_all", out_all_erased, 0);
        chk("rst_rdy", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_one(3'd5, 3'd2, 2'b00, 1'b0, 16'h7A47, 2'd1, 1'b0);
        run_one(3'd5, 3'd2, 2'b10, 1'b0, 16'h2525, 2'd1, 1'b0);
        run_one(3'd5, 3'd2, 2'b00, 1'b1, 16'h7E07, 2'd1, 1'b0);
        run_one(3'd5, 3'd2, 2'b11, 1'b0, 16'h0000, 2'd0, 1'b1);
        run_one(3'd7, 3'd7, 2'b00, 1'b0, 16'h077E, 2'd3, 1'b0);

        // Backpressure: four beats against a stalled sink.
        bp[0] = 6'o25; bp[1] = 6'o03; bp[2] = 6'o61; bp[3] = 6'o74;
        for (int i = 0; i < 4; i++) bexp[i] = model_main(bp[i], 2'b00, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        sent = 0;
        nacc = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_soft = bp[sent];
            in_erase = '0;
            in_hard = 1'b0;
            @(negedge clk);
            acc = in_ready;
            if (acc) nacc++;
            if (c >= 2)
                chk("bp_hold", {out_valid, out_all_erased, out_min_idx, out_metric},
                    {1'b1, bexp[0]});
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        chk("bp_accepted", nacc, 2);
        chk("bp_rdy", in_ready, 0);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = sent < 4;
            in_soft = bp[sent & 3];
            @(negedge clk);
            acc = in_valid && in_ready;
            chk("bp_ov", out_valid, 1);
            chk("bp_order", {out_all_erased, out_min_idx, out_metric}, bexp[got]);
            got++;
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Async reset with two beats in flight.
        #1;
        in_valid = 1'b1;
        in_soft = 6'o66;
        @(posedge clk);
        #1 in_soft = 6'o13;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_ov", out_valid, 0);
        chk("arst_metric", out_metric, 0);
        chk("arst_min", out_min_idx, 0);
        chk("arst_all", out_all_erased, 0);
        chk("arst_rdy", in_ready, 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_one(3'd5, 3'd2, 2'b00, 1'b0, 16'h7A47, 2'd1, 1'b0);

        // Random traffic against the model.
        @(posedge clk);
        #1;
        acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || acc) begin
                in_valid = $urandom_range(0, 3) != 0;
                in_soft = 6'($urandom);
                in_erase = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
                in_hard = 1'($urandom_range(0, 1));
            end
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        chk("drain", q.size(), 0);

        fork
            wait (ldone);
            repeat (20000) @(posedge clk);
        join_any
        chk("leg_done", ldone, 1);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
